bin_to_bcd: RTL and testbench



---
 rtl/bin_to_bcd.sv | 108 ++++++++++
 tb/tb_bin_to_bcd.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd.sv
// Sequential 16-bit binary to 4-digit packed BCD converter (double dabble, one bit per clock).
// Optional build macro BCD_SATURATE_EN: results above 9999 read 16'h9999 instead of value mod 10000.
module bin_to_bcd (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] bin,
    output logic [15:0] BCD,
    output logic        busy,
    output logic        done,
    output logic        ovf
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] shift_q, shift_d;
    logic [19:0] scratch_q, scratch_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] bcd_q, bcd_d;
    logic        ovf_q, ovf_d;
    logic        done_q, done_d;

    logic [19:0] scratch_adj;
    logic [19:0] scratch_shifted;
    logic [15:0] result_bcd;
    logic        result_ovf;

    // Digits only ever hold 0..9 here, so +3 on a digit of 5..9 stays within 4 bits.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_digit_adj
            assign scratch_adj[gi*4 +: 4] = (scratch_q[gi*4 +: 4] >= 4'd5)
                                          ? scratch_q[gi*4 +: 4] + 4'd3
                                          : scratch_q[gi*4 +: 4];
        end
    endgenerate

    assign scratch_shifted = {scratch_adj[18:0], shift_q[15]};
    assign result_ovf      = (scratch_shifted[19:16] != 4'd0);

`ifdef BCD_SATURATE_EN
    assign result_bcd = result_ovf ? 16'h9999 : scratch_shifted[15:0];
`else
    assign result_bcd = scratch_shifted[15:0];
`endif

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d   = bin;
                    scratch_d = 20'd0;
                    cnt_d     = 4'd0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                shift_d   = {shift_q[14:0], 1'b0};
                scratch_d = scratch_shifted;
                cnt_d     = cnt_q + 4'd1;
                // cnt_q == 15 marks the sixteenth iteration: publish the result.
                if (cnt_q == 4'd15) begin
                    bcd_d   = result_bcd;
                    ovf_d   = result_ovf;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= 16'd0;
            scratch_q <= 20'd0;
            cnt_q     <= 4'd0;
            bcd_q     <= 16'h0000;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    assign BCD  = bcd_q;
    assign ovf  = ovf_q;
    assign done = done_q;
    assign busy = (state_q == SHIFT);

endmodule

// File: tb/tb_bin_to_bcd.sv
// Self-checking bench for bin_to_bcd: cycle model of busy/done/BCD/ovf plus directed literal checks.
// Honours BCD_SATURATE_EN the same way as the design build.
module tb_bin_to_bcd;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] bin;
    logic [15:0] BCD;
    logic        busy;
    logic        done;
    logic        ovf;

    int compares = 0;
    int errors   = 0;

    bin_to_bcd dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bin),
        .BCD   (BCD),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Expected display word from plain decimal arithmetic.
    function automatic logic [15:0] expect_bcd(input int v);
        int t;
        logic [15:0] r;
`ifdef BCD_SATURATE_EN
        if (v > 9999) return 16'h9999;
`endif
        t = v % 10000;
        r = {4'((t / 1000) % 10), 4'((t / 100) % 10), 4'((t / 10) % 10), 4'(t % 10)};
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp_v);
        compares++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Transaction-level model: an accepted request becomes a result 16 edges later.
    logic        m_busy;
    logic        m_done;
    logic [15:0] m_bcd;
    logic        m_ovf;
    int          m_left;
    int          m_val;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_bcd  <= 16'h0000;
            m_ovf  <= 1'b0;
            m_left <= 0;
            m_val  <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_bcd  <= expect_bcd(m_val);
                    m_ovf  <= (m_val > 9999);
                end
                m_left <= m_left - 1;
            end else if (start) begin
                m_busy <= 1'b1;
                m_left <= 16;
                m_val  <= int'(bin);
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", int'(busy), int'(m_busy));
        chk("done", int'(done), int'(m_done));
        chk("BCD",  int'(BCD),  int'(m_bcd));
        chk("ovf",  int'(ovf),  int'(m_ovf));
        if (done)
            $display("result: bin=%0d BCD=%h ovf=%0b", m_val, BCD, ovf);
    end

    // Pulse start with a value, then require done exactly 16 edges after acceptance.
    task automatic convert(input logic [15:0] val, input logic [15:0] exp_bcd, input logic exp_ovf);
        int lat;
        @(posedge clk); #1;
        start = 1'b1;
        bin   = val;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        chk("latency", lat, 16);
        chk("literal_BCD", int'(BCD), int'(exp_bcd));
        chk("literal_ovf", int'(ovf), int'(exp_ovf));
    endtask

    initial begin
        int ndone;
        reset = 1'b1;
        start = 1'b0;
        bin   = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_BCD",  int'(BCD),  0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_ovf",  int'(ovf),  0);
        reset = 1'b0;

        convert(16'd0,    16'h0000, 1'b0);
        convert(16'd1234, 16'h1234, 1'b0);
        convert(16'd9999, 16'h9999, 1'b0);
`ifdef BCD_SATURATE_EN
        convert(16'd10000, 16'h9999, 1'b1);
        convert(16'd65535, 16'h9999, 1'b1);
`else
        convert(16'd10000, 16'h0000, 1'b1);
        convert(16'd65535, 16'h5535, 1'b1);
`endif

        // Start during busy is ignored; the earlier result holds until completion.
        @(posedge clk); #1;
        start = 1'b1;
        bin   = 16'd42;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 5) begin
                start = 1'b1;
                bin   = 16'd77;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) ndone++;
            if (i == 15) chk("hold_prev_BCD", int'(BCD), int'(expect_bcd(65535)));
        end
        chk("ignored_start_done_count", ndone, 1);
        chk("ignored_start_BCD", int'(BCD), 16'h0042);

        // Asynchronous reset mid-conversion.
        @(posedge clk); #1;
        start = 1'b1;
        bin   = 16'd5678;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_BCD",  int'(BCD),  0);
        chk("async_busy", int'(busy), 0);
        chk("async_done", int'(done), 0);
        chk("async_ovf",  int'(ovf),  0);
        @(posedge clk); #1;
        reset = 1'b0;
        convert(16'd5678, 16'h5678, 1'b0);

        // Start held with incrementing bin: one conversion every 17 clocks.
        @(posedge clk); #1;
        start = 1'b1;
        bin   = 16'd100;
        ndone = 0;
        for (int i = 1; i <= 85; i++) begin
            @(posedge clk); #1;
            bin = bin + 16'd1;
            if (done) ndone++;
        end
        start = 1'b0;
        chk("back_to_back_done_count", ndone, 5);
        chk("back_to_back_last_BCD", int'(BCD), 16'h0168);
        repeat (20) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
        $finish;
    end

endmodule
